// File: rtl/multu_unit_pkg.sv
// Shared processor definitions for the multicycle unsigned multiplier:
// FSM state encodings and the default operand width.
package multu_unit_pkg;

    localparam int MULTU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } multu_state_t;

endpackage

// File: rtl/multu_unit.sv
// Multicycle shift-and-add unsigned multiplier (multu) with HI/LO result
// registers; one multiplier bit is retired per RUN cycle.
module multu_unit
    import multu_unit_pkg::*;
#(
    parameter int WIDTH = MULTU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_out
);

    multu_state_t       state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     sum;

    // Keep the adder carry: it becomes the new MSB after the right shift.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplr[0] ? mcand : {WIDTH{1'b0}})};
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        mcand <= srca;
                        mplr  <= srcb;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= {sum, acc[WIDTH-1:1]};
                    mplr <= mplr >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi    <= acc[2*WIDTH-1:WIDTH];
                    lo    <= acc[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign hilo_out = hi_lo ? lo : hi;

endmodule

// File: doc/multu_unit.md
MULTU_UNIT -- requirements
Module: multu_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand width in bits; HI and LO are each WIDTH bits.
REQ-002 The block SHALL have parameter CNT_W, default 6, the width of the iteration counter; CNT_W SHALL be wide enough to hold the value WIDTH.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin a multu of srca and srcb.
REQ-006 The block SHALL have ports srca and srcb, input, WIDTH bits each, unsigned operands from the register file; they are sampled only when start is accepted.
REQ-007 The block SHALL have port hi_lo, input, 1 bit, the read select: 0 selects HI, 1 selects LO.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a multiply is in progress; the datapath uses it as a stall.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the cycle HI and LO first hold the new product.
REQ-010 The block SHALL have port hilo_out, output, WIDTH bits, the HI or LO value chosen by hi_lo; this feeds the datapath result mux for mfhi and mflo.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-012 IDLE: start=1 SHALL load the multiplicand from srca, the multiplier from srcb, clear the 2*WIDTH accumulator and the counter, and move to RUN.
REQ-013 IDLE: start=0 SHALL leave the FSM in IDLE.
REQ-014 RUN: each cycle, when the multiplier LSB is 1 the block SHALL add the multiplicand into the upper half of the accumulator; it SHALL then shift the accumulator, carry included, right by 1, shift the multiplier right by 1, and increment the counter.
REQ-015 RUN: the carry out of the WIDTH-bit add SHALL be kept, because the product never overflows 2*WIDTH bits.
REQ-016 RUN: after exactly WIDTH iterations the FSM SHALL move to DONE.
REQ-017 DONE: the block SHALL write HI = accumulator[2W-1:W], write LO = accumulator[W-1:0], assert done=1, and return to IDLE on the next edge.
REQ-018 Latency: if start is accepted at edge N, busy SHALL be 1 from N+1 through N+WIDTH, done SHALL be 1 during the cycle after edge N+WIDTH+1, and HI/LO SHALL be updated at that same edge.
REQ-019 busy SHALL equal (state==RUN) and SHALL be registered-state based, with no combinational path from start.
REQ-020 start asserted in RUN or DONE SHALL be ignored: no restart and no operand resample.
REQ-021 HI and LO SHALL hold their previous values until DONE; reads during RUN SHALL return the previous product.
REQ-022 hilo_out SHALL be combinational from hi_lo and the HI/LO registers only.
REQ-023 Back-to-back operation: start asserted during the done cycle SHALL be ignored; start is accepted again in the following IDLE cycle.
REQ-024 Operands of 0: the full WIDTH cycles SHALL still run (no early exit), giving HI=LO=0.

Reset
REQ-025 Asserting reset (low) at any time, including mid-RUN, SHALL force IDLE, clear the counter, multiplicand, multiplier and accumulator, set HI=0 and LO=0, and drive busy=0 and done=0.
REQ-026 The in-flight multiply SHALL be discarded and SHALL NOT complete after reset is released.
REQ-027 After reset is deasserted, the first rising edge SHALL be able to accept start.

Structure
REQ-028 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared processor package/header used by the datapath and controller.
REQ-029 The design SHALL be a single module with no sub-modules; the adder is inline.
REQ-030 Integration: the controller drives start from the multu decode (hi_lo_load), and the datapath stalls the PC and suppresses regwrite while busy=1.

Verification
REQ-031 The bench SHALL drive srca=30, srcb=31, start for 1 cycle; it SHALL check busy for exactly 32 cycles, then done for 1 cycle, then LO=930 (hi_lo=1) and HI=0 (hi_lo=0).
REQ-032 The bench SHALL drive srca=srcb=32'hFFFFFFFF and check HI=32'hFFFFFFFE and LO=32'h00000001.
REQ-033 The bench SHALL complete 7*6, then start 3*5 and hold start=1 through RUN; it SHALL check a single done and HI/LO=0/15, with the start during RUN ignored.
REQ-034 The bench SHALL start 12345*678, assert reset low at RUN cycle 10, then release it; it SHALL check HI=LO=0, busy=0 immediately, and no done pulse afterwards.
REQ-035 The bench SHALL, during a RUN of 2*3 after a prior product of 930, read LO and check that it returns 930 until done, then 6.
REQ-036 The bench SHALL drive srca=0, srcb=32'h80000000 and check busy for the full 32 cycles, then HI=LO=0.
